// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer: FSM state encoding
// and the default data-memory wait timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2,
    ERR      = 2'd3
  } state_e;

  localparam int MEM_TIMEOUT_DEFAULT = 16;
  localparam int WAIT_CNT_W          = 8;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX
// is still fetching. Register $0 is hard-wired and never creates a dependency.
module load_use_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  assign load_use_o = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use bubbles, taken-branch
// flushes and data-memory freezes. Optional saturating statistics under HAZARD_STATS_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             MEM_BranchTaken,
  input  logic             MEM_MemAccess,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             Freeze,
  output logic             mem_timeout,
  output logic [1:0]       state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255) || (CNT_W < 1)) begin : g_param_check
    $error("hazard_stall_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W at least 1");
  end

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
  logic                    timeout_q, timeout_d;
  logic                    load_use;
  logic                    mem_stall;

  load_use_detect u_load_use_detect (
    .ex_mem_read_i (EX_MemRead),
    .ex_rt_i       (EX_Rt),
    .id_rs_i       (ID_Rs),
    .id_rt_i       (ID_Rt),
    .id_uses_rt_i  (ID_UsesRt),
    .load_use_o    (load_use)
  );

  assign mem_stall = MEM_MemAccess && !dmem_ready;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    timeout_d   = timeout_q;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    Freeze      = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          Freeze     = 1'b1;
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          state_d    = MEM_WAIT;
          wcnt_d     = WAIT_CNT_W'(1);
        end else if (MEM_BranchTaken) begin
          IFID_Flush  = 1'b1;
          IDEX_Flush  = 1'b1;
          EXMEM_Flush = 1'b1;
          state_d     = BR_FLUSH;
        end else if (load_use) begin
          // One bubble suffices: the load leaves EX on the next edge.
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          Freeze     = 1'b1;
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          if (wcnt_q == TIMEOUT_LIM) begin
            timeout_d = 1'b1;
            state_d   = ERR;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      // ID holds the bubble just inserted, so no load-use check here.
      BR_FLUSH: state_d = RUN;

      ERR: begin
        Freeze     = 1'b1;
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign state_o     = state_q;
  assign mem_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_q, flush_q, wait_q;

  assign stall_evt = (state_q == RUN) && !mem_stall && !MEM_BranchTaken && load_use;
  assign flush_evt = (state_q == RUN) && !mem_stall && MEM_BranchTaken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (stall_evt && (stall_q != CNT_MAX)) stall_q <= stall_q + 1'b1;
      if (flush_evt && (flush_q != CNT_MAX)) flush_q <= flush_q + 1'b1;
      if ((state_q == MEM_WAIT) && (wait_q != CNT_MAX)) wait_q <= wait_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign wait_cnt  = wait_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expected outputs,
// a monitor pops and compares whenever a sample is presented.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       ID_UsesRt, EX_MemRead, MEM_BranchTaken, MEM_MemAccess, dmem_ready;
  logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze, mem_timeout;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  event       sample_ev;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_Rs           (ID_Rs),
    .ID_Rt           (ID_Rt),
    .ID_UsesRt       (ID_UsesRt),
    .EX_MemRead      (EX_MemRead),
    .EX_Rt           (EX_Rt),
    .MEM_BranchTaken (MEM_BranchTaken),
    .MEM_MemAccess   (MEM_MemAccess),
    .dmem_ready      (dmem_ready),
    .PCWrite         (PCWrite),
    .IFID_Write      (IFID_Write),
    .IFID_Flush      (IFID_Flush),
    .IDEX_Flush      (IDEX_Flush),
    .EXMEM_Flush     (EXMEM_Flush),
    .Freeze          (Freeze),
    .mem_timeout     (mem_timeout),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  // Packed as {state, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze, mem_timeout}
  function automatic logic [8:0] mk(input logic [1:0] st, input logic pc, iw, ifl, idf, exf, fz, to);
    return {st, pc, iw, ifl, idf, exf, fz, to};
  endfunction

  localparam logic [8:0] E_RUN   = {2'd0, 7'b1100000};
  localparam logic [8:0] E_STALL = {2'd0, 7'b0001000};
  localparam logic [8:0] E_BR    = {2'd0, 7'b1111100};
  localparam logic [8:0] E_BRF   = {2'd2, 7'b1100000};
  localparam logic [8:0] E_FRZ0  = {2'd0, 7'b0000010};
  localparam logic [8:0] E_FRZW  = {2'd1, 7'b0000010};
  localparam logic [8:0] E_REL   = {2'd1, 7'b1100000};
  localparam logic [8:0] E_ERR   = {2'd3, 7'b0000011};

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%b required=%b (state,PCWrite,IFID_Write,IFID_Flush,IDEX_Flush,EXMEM_Flush,Freeze,mem_timeout)",
               nm, act, exp);
    end
  endtask

  // Monitor: independent of stimulus, compares each presented sample against the queue head.
  always begin
    @(sample_ev);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL monitor: sample presented with no expected entry queued");
    end else begin
      check(name_q.pop_front(),
            {state_o, PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze, mem_timeout},
            exp_q.pop_front());
    end
  end

  task automatic drive(input logic [4:0] rs, rt, input logic ur, mr, input logic [4:0] ert,
                       input logic br, acc, rdy);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ur; EX_MemRead = mr; EX_Rt = ert;
    MEM_BranchTaken = br; MEM_MemAccess = acc; dmem_ready = rdy;
  endtask

  // One pipeline cycle: drive just after the edge, sample on the falling edge.
  task automatic cyc(input string nm, input logic [4:0] rs, rt, input logic ur, mr,
                     input logic [4:0] ert, input logic br, acc, rdy, input logic [8:0] exp);
    @(posedge clk);
    #1;
    drive(rs, rt, ur, mr, ert, br, acc, rdy);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    ->sample_ev;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #3;
    exp_q.push_back(mk(2'd0, 1, 1, 0, 0, 0, 0, 0));
    name_q.push_back("reset_state");
    ->sample_ev;
    @(negedge clk);
    reset = 1'b0;

    //                        rs     rt     ur mr ert    br acc rdy  expected
    cyc("load_use_rs",        5'd5,  5'd0,  0, 1, 5'd5,  0, 0,  1,   E_STALL);
    cyc("load_use_released",  5'd5,  5'd0,  0, 0, 5'd5,  0, 0,  1,   E_RUN);
    cyc("load_use_r0",        5'd0,  5'd0,  1, 1, 5'd0,  0, 0,  1,   E_RUN);
    cyc("rt_not_used",        5'd3,  5'd7,  0, 1, 5'd7,  0, 0,  1,   E_RUN);
    cyc("load_use_rt",        5'd3,  5'd7,  1, 1, 5'd7,  0, 0,  1,   E_STALL);
    cyc("after_rt_stall",     5'd3,  5'd7,  1, 0, 5'd7,  0, 0,  1,   E_RUN);
    cyc("branch_taken",       5'd0,  5'd0,  0, 0, 5'd0,  1, 0,  1,   E_BR);
    cyc("br_flush_no_stall",  5'd5,  5'd0,  0, 1, 5'd5,  0, 0,  1,   E_BRF);
    cyc("after_br_flush",     5'd0,  5'd0,  0, 0, 5'd0,  0, 0,  1,   E_RUN);
    cyc("branch_beats_lu",    5'd5,  5'd0,  0, 1, 5'd5,  1, 0,  1,   E_BR);
    cyc("br_flush_2",         5'd0,  5'd0,  0, 0, 5'd0,  0, 0,  1,   E_BRF);
    cyc("mem_ready_no_wait",  5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  1,   E_RUN);

    // Memory wait: three frozen cycles, released in the ready cycle.
    cyc("wait_enter",         5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZ0);
    cyc("wait_1",             5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZW);
    cyc("wait_2",             5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZW);
    cyc("wait_release",       5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  1,   E_REL);
    cyc("wait_back_run",      5'd0,  5'd0,  0, 0, 5'd0,  0, 0,  1,   E_RUN);

    // Memory stall beats branch and load-use; the held branch is acted on after release.
    cyc("mem_beats_all",      5'd5,  5'd0,  0, 1, 5'd5,  1, 1,  0,   E_FRZ0);
    cyc("wait_branch_held",   5'd5,  5'd0,  0, 1, 5'd5,  1, 1,  1,   E_REL);
    cyc("branch_after_wait",  5'd0,  5'd0,  0, 0, 5'd0,  1, 0,  1,   E_BR);
    cyc("br_flush_3",         5'd0,  5'd0,  0, 0, 5'd0,  0, 0,  1,   E_BRF);
    cyc("run_again",          5'd0,  5'd0,  0, 0, 5'd0,  0, 0,  1,   E_RUN);

    // Timeout with MEM_TIMEOUT=4: ERR after the fourth MEM_WAIT cycle.
    cyc("to_enter",           5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZ0);
    cyc("to_wait_1",          5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZW);
    cyc("to_wait_2",          5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZW);
    cyc("to_wait_3",          5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZW);
    cyc("to_wait_4",          5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_FRZW);
    cyc("to_err",             5'd0,  5'd0,  0, 0, 5'd0,  0, 1,  0,   E_ERR);
    cyc("err_held",           5'd5,  5'd0,  0, 1, 5'd5,  1, 1,  1,   E_ERR);

    // Asynchronous reset in ERR, sampled before any further clock edge.
    #1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    exp_q.push_back(E_RUN);
    name_q.push_back("async_reset_in_err");
    ->sample_ev;
    @(negedge clk);
    reset = 1'b0;
    cyc("run_after_reset",    5'd0,  5'd0,  0, 0, 5'd0,  0, 0,  1,   E_RUN);

    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries left, required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
